// File: rtl/axis_arb_pkg.sv
// rtl/axis_arb_pkg.sv - shared types and round-robin helper for the TX frame arbiter
//
// Purpose: state encoding and the cyclic winner search used by axis_tx_frame_arbiter.
// Contents:
//   arb_state_t  IDLE / PASS / DRAIN
//   rr_next      first requester strictly after ptr, wrapping at n-1
package axis_arb_pkg;

  localparam int ARB_MAX_SRC = 8;

  typedef enum logic [1:0] {ARB_IDLE, ARB_PASS, ARB_DRAIN} arb_state_t;

  // Scans from the farthest position back to ptr+1 so the nearest requester
  // after ptr overwrites the others. ptr itself is n steps away, so a lone
  // request from the previous winner is still served.
  function automatic logic [2:0] rr_next(input logic [ARB_MAX_SRC-1:0] req,
                                         input logic [2:0]             ptr,
                                         input int                     n);
    logic [2:0] win;
    logic [2:0] idx;
    win = ptr;
    for (int k = ARB_MAX_SRC; k >= 1; k--) begin
      if (k <= n) begin
        idx = 3'((int'(ptr) + k) % n);
        if (req[idx]) win = idx;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/axis_reg_slice.sv
// rtl/axis_reg_slice.sv - single-entry ready/valid output register
//
// Purpose: one-deep pipeline register between an upstream and downstream stream.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   s_tdata/s_tvalid/s_tlast/s_tuser upstream beat
//   s_trdy                          upstream ready (register empty or emptying)
//   m_tdata/m_tvalid/m_tlast/m_tuser registered beat
//   m_trdy                          downstream ready
module axis_reg_slice #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic                  s_tuser,
  output logic                  s_trdy,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic                  m_tuser,
  input  logic                  m_trdy
);

  assign s_trdy = !m_tvalid || m_trdy;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_tdata  <= '0;
      m_tvalid <= 1'b0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else if (s_tvalid && s_trdy) begin
      m_tdata  <= s_tdata;
      m_tvalid <= 1'b1;
      m_tlast  <= s_tlast;
      m_tuser  <= s_tuser;
    end else if (m_trdy) begin
      m_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/axis_tx_frame_arbiter.sv
// rtl/axis_tx_frame_arbiter.sv - frame-level round-robin arbiter with stall watchdog
//
// Purpose: shares one AXI-Stream TX path between NUM_SRC sources, one whole frame
// per grant. A source that stalls mid-frame gets its frame terminated with a bad
// (tuser=1) tlast beat; the remainder of that frame is then swallowed.
// Ports:
//   s_aclk, s_sreset            clock, synchronous active-high reset
//   s_axis_*                    per-source streams, source i data at [i*W +: W]
//   m_axis_*                    registered output stream toward the TX FIFO
//   grant_idx                   currently granted source (meaningful while busy)
//   busy                        high in PASS or DRAIN
//   abort_pulse                 one-cycle pulse when the watchdog terminates a frame
module axis_tx_frame_arbiter
  import axis_arb_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 8,
  parameter int NUM_SRC        = 2,
  parameter int STALL_TIMEOUT  = 256
) (
  input  logic                              s_aclk,
  input  logic                              s_sreset,
  input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]                s_axis_tvalid,
  input  logic [NUM_SRC-1:0]                s_axis_tlast,
  input  logic [NUM_SRC-1:0]                s_axis_tuser,
  output logic [NUM_SRC-1:0]                s_axis_trdy,
  output logic [AXI_DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                              m_axis_tvalid,
  output logic                              m_axis_tlast,
  output logic                              m_axis_tuser,
  input  logic                              m_axis_trdy,
  output logic [$clog2(NUM_SRC)-1:0]        grant_idx,
  output logic                              busy,
  output logic                              abort_pulse
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int CW = $clog2(STALL_TIMEOUT);
  localparam logic [CW-1:0] STALL_LAST = CW'(STALL_TIMEOUT - 1);

  arb_state_t              state, state_nxt;
  logic [GW-1:0]           grant_nxt, rr_ptr, rr_ptr_nxt;
  logic [CW-1:0]           stall_cnt, stall_cnt_nxt;
  logic                    abort_nxt;

  logic [AXI_DATA_WIDTH-1:0] src_tdata;
  logic                      src_tvalid, src_tlast, src_tuser;

  logic [AXI_DATA_WIDTH-1:0] sl_tdata;
  logic                      sl_tvalid, sl_tlast, sl_tuser, sl_trdy;

  assign src_tdata  = s_axis_tdata[int'(grant_idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
  assign src_tvalid = s_axis_tvalid[grant_idx];
  assign src_tlast  = s_axis_tlast[grant_idx];
  assign src_tuser  = s_axis_tuser[grant_idx];
  assign busy       = (state != ARB_IDLE);

  always_ff @(posedge s_aclk) begin
    if (s_sreset) begin
      state       <= ARB_IDLE;
      grant_idx   <= '0;
      rr_ptr      <= GW'(NUM_SRC - 1);
      stall_cnt   <= '0;
      abort_pulse <= 1'b0;
    end else begin
      state       <= state_nxt;
      grant_idx   <= grant_nxt;
      rr_ptr      <= rr_ptr_nxt;
      stall_cnt   <= stall_cnt_nxt;
      abort_pulse <= abort_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    grant_nxt     = grant_idx;
    rr_ptr_nxt    = rr_ptr;
    stall_cnt_nxt = stall_cnt;
    abort_nxt     = 1'b0;
    s_axis_trdy   = '0;
    sl_tdata      = '0;
    sl_tvalid     = 1'b0;
    sl_tlast      = 1'b0;
    sl_tuser      = 1'b0;

    case (state)
      ARB_IDLE: begin
        stall_cnt_nxt = '0;
        if (|s_axis_tvalid) begin
          grant_nxt  = GW'(rr_next(ARB_MAX_SRC'(s_axis_tvalid), 3'(rr_ptr), NUM_SRC));
          rr_ptr_nxt = grant_nxt;
          state_nxt  = ARB_PASS;
        end
      end

      ARB_PASS: begin
        // Ready only follows the register, so a new frame can never enter
        // while the previous frame's last beat is still stuck downstream.
        s_axis_trdy[grant_idx] = sl_trdy;
        if (src_tvalid) begin
          sl_tvalid = 1'b1;
          sl_tdata  = src_tdata;
          sl_tlast  = src_tlast;
          sl_tuser  = src_tuser;
          // Backpressure holds the count; only a real beat clears it.
          if (sl_trdy) begin
            stall_cnt_nxt = '0;
            if (src_tlast) state_nxt = ARB_IDLE;
          end
        end else if (stall_cnt == STALL_LAST) begin
          // Terminating beat; the count saturates until the register frees up.
          sl_tvalid = 1'b1;
          sl_tlast  = 1'b1;
          sl_tuser  = 1'b1;
          if (sl_trdy) begin
            abort_nxt     = 1'b1;
            stall_cnt_nxt = '0;
            state_nxt     = ARB_DRAIN;
          end
        end else begin
          stall_cnt_nxt = stall_cnt + 1'b1;
        end
      end

      ARB_DRAIN: begin
        s_axis_trdy[grant_idx] = 1'b1;
        if (src_tvalid && src_tlast) state_nxt = ARB_IDLE;
      end

      default: state_nxt = ARB_IDLE;
    endcase
  end

  axis_reg_slice #(
    .DATA_WIDTH(AXI_DATA_WIDTH)
  ) u_out_reg (
    .clk      (s_aclk),
    .reset    (s_sreset),
    .s_tdata  (sl_tdata),
    .s_tvalid (sl_tvalid),
    .s_tlast  (sl_tlast),
    .s_tuser  (sl_tuser),
    .s_trdy   (sl_trdy),
    .m_tdata  (m_axis_tdata),
    .m_tvalid (m_axis_tvalid),
    .m_tlast  (m_axis_tlast),
    .m_tuser  (m_axis_tuser),
    .m_trdy   (m_axis_trdy)
  );

endmodule

// File: tb/tb_axis_tx_frame_arbiter.sv
// tb/tb_axis_tx_frame_arbiter.sv - self-checking bench for axis_tx_frame_arbiter
module tb_axis_tx_frame_arbiter;

  localparam int W   = 8;
  localparam int NS  = 3;
  localparam int TMO = 16;

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       user;
    int         gap;
    int         cyc;
  } beat_t;

  typedef struct {
    int         src;
    int         len;
    logic [7:0] base;
    logic       user_last;
    int         exp_grant;
    logic       exp_last_user;
  } vec_t;

  logic              clk = 1'b0;
  logic              s_sreset;
  logic [NS*W-1:0]   s_axis_tdata;
  logic [NS-1:0]     s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_trdy;
  logic [W-1:0]      m_axis_tdata;
  logic              m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_trdy;
  logic [$clog2(NS)-1:0] grant_idx;
  logic              busy, abort_pulse;

  always #5 clk = ~clk;

  axis_tx_frame_arbiter #(
    .AXI_DATA_WIDTH(W),
    .NUM_SRC(NS),
    .STALL_TIMEOUT(TMO)
  ) dut (
    .s_aclk        (clk),
    .s_sreset      (s_sreset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_trdy   (s_axis_trdy),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_trdy   (m_axis_trdy),
    .grant_idx     (grant_idx),
    .busy          (busy),
    .abort_pulse   (abort_pulse)
  );

  beat_t sq[NS][$];
  beat_t exp_q[$];
  beat_t out_q[$];
  int    hs_cyc_q[$];
  int    hs_grant_q[$];
  int    wait_c[NS];
  bit    rnd_trdy, chk_bp;
  int    cyc, abort_cnt, bp_viol;
  int    n_cmp, n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit all_empty();
    for (int s = 0; s < NS; s++) if (sq[s].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic clear_logs();
    exp_q.delete(); out_q.delete(); hs_cyc_q.delete(); hs_grant_q.delete();
    abort_cnt = 0; bp_viol = 0;
  endtask

  // Sample at negedge, then advance sources/sink just after the next posedge.
  task automatic cycle();
    logic [NS-1:0] hs;
    @(negedge clk);
    hs = s_axis_tvalid & s_axis_trdy;
    for (int s = 0; s < NS; s++)
      if (hs[s]) begin hs_cyc_q.push_back(cyc); hs_grant_q.push_back(int'(grant_idx)); end
    if (m_axis_tvalid && m_axis_trdy)
      out_q.push_back('{m_axis_tdata, m_axis_tlast, m_axis_tuser, 0, cyc});
    if (chk_bp && m_axis_tvalid && !m_axis_trdy && s_axis_trdy != '0) bp_viol++;
    if (abort_pulse) abort_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    for (int s = 0; s < NS; s++) begin
      if (hs[s] && sq[s].size() > 0) begin
        void'(sq[s].pop_front());
        wait_c[s] = 0;
      end
      if (sq[s].size() > 0 && wait_c[s] >= sq[s][0].gap) begin
        s_axis_tvalid[s]       = 1'b1;
        s_axis_tdata[s*W +: W] = sq[s][0].data;
        s_axis_tlast[s]        = sq[s][0].last;
        s_axis_tuser[s]        = sq[s][0].user;
      end else begin
        s_axis_tvalid[s] = 1'b0;
        s_axis_tlast[s]  = 1'b0;
        s_axis_tuser[s]  = 1'b0;
        if (sq[s].size() > 0) wait_c[s]++;
      end
    end
    m_axis_trdy = rnd_trdy ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run_until_idle(input string name, input int budget);
    int n;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!(all_empty() && !m_axis_tvalid && !busy) && n < budget);
    n_cmp++;
    if (n >= budget) begin
      n_bad++;
      $display("FAIL %s_timeout: still busy after %0d cycles, expected idle", name, n);
    end
  endtask

  // Queues a frame on source s; optionally also appends it to the expected output.
  task automatic add_frame(input int s, input int len, input logic [7:0] base,
                           input logic user_last, input bit rnd,
                           input int stall_at, input int stall_len, input bit push_exp);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = rnd ? 8'($urandom) : 8'(base + 8'(i));
      b.last = (i == len - 1);
      b.user = rnd ? 1'($urandom_range(0, 1)) : (b.last & user_last);
      b.gap  = (i == stall_at) ? stall_len : ((rnd && i > 0) ? $urandom_range(0, 3) : 0);
      b.cyc  = 0;
      sq[s].push_back(b);
      if (push_exp) exp_q.push_back(b);
    end
  endtask

  task automatic compare_out(input string name);
    chk($sformatf("%s_len", name), out_q.size(), exp_q.size());
    for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_beat%0d", name, i),
          {out_q[i].data, out_q[i].last, out_q[i].user},
          {exp_q[i].data, exp_q[i].last, exp_q[i].user});
  endtask

  task automatic check_reset(input string p);
    chk({p, "_m_tvalid"}, m_axis_tvalid, 0);
    chk({p, "_m_tlast"},  m_axis_tlast, 0);
    chk({p, "_m_tuser"},  m_axis_tuser, 0);
    chk({p, "_m_tdata"},  m_axis_tdata, 0);
    chk({p, "_s_trdy"},   s_axis_trdy, 0);
    chk({p, "_grant"},    grant_idx, 0);
    chk({p, "_busy"},     busy, 0);
    chk({p, "_abort"},    abort_pulse, 0);
  endtask

  task automatic test_table();
    vec_t tbl[4];
    tbl[0] = '{0, 60, 8'h00, 1'b0, 0, 1'b0};
    tbl[1] = '{2,  1, 8'h40, 1'b0, 2, 1'b0};
    tbl[2] = '{0,  2, 8'hA0, 1'b1, 0, 1'b1};
    tbl[3] = '{1,  5, 8'h80, 1'b1, 1, 1'b1};
    for (int t = 0; t < 4; t++) begin
      clear_logs();
      add_frame(tbl[t].src, tbl[t].len, tbl[t].base, tbl[t].user_last, 1'b0, -1, 0, 1'b1);
      run_until_idle($sformatf("tbl%0d", t), 500);
      compare_out($sformatf("tbl%0d", t));
      if (out_q.size() > 0 && hs_cyc_q.size() > 0) begin
        chk($sformatf("tbl%0d_last_user", t), out_q[out_q.size()-1].user, tbl[t].exp_last_user);
        chk($sformatf("tbl%0d_grant", t), hs_grant_q[0], tbl[t].exp_grant);
        chk($sformatf("tbl%0d_lat_first", t), out_q[0].cyc - hs_cyc_q[0], 1);
        chk($sformatf("tbl%0d_lat_last", t),
            out_q[out_q.size()-1].cyc - hs_cyc_q[hs_cyc_q.size()-1], 1);
      end else begin
        chk($sformatf("tbl%0d_any_output", t), out_q.size(), tbl[t].len);
      end
      chk($sformatf("tbl%0d_abort", t), abort_cnt, 0);
    end
  endtask

  // Table leaves the pointer at source 1, so source 0 is next in line.
  task automatic test_pingpong();
    clear_logs();
    for (int f = 0; f < 3; f++)
      for (int s = 0; s < 2; s++)
        add_frame(s, 64, 8'(s * 128 + f * 16), 1'b0, 1'b0, -1, 0, 1'b1);
    run_until_idle("pp", 1000);
    compare_out("pp");
    for (int i = 0; i + 1 < out_q.size(); i++)
      if (out_q[i].last)
        chk($sformatf("pp_gap_after%0d", i), out_q[i+1].cyc - out_q[i].cyc, 2);
    chk("pp_abort", abort_cnt, 0);
  endtask

  // Reference order: every source with frames left is always requesting, so
  // frames are served in strict rotation starting after the last winner.
  task automatic test_random();
    int rem[NS];
    int ptr, total, c, cand;
    bit first, found;
    rem = '{3, 1, 2};
    total = 6;
    ptr = 1;
    first = 1'b1;
    clear_logs();
    while (total > 0) begin
      c = ptr;
      found = 1'b0;
      for (int k = 1; k <= NS; k++) begin
        cand = (ptr + k) % NS;
        if (!found && rem[cand] > 0) begin c = cand; found = 1'b1; end
      end
      add_frame(c, first ? 1500 : $urandom_range(1, 48), 8'h00, 1'b0, 1'b1, -1, 0, 1'b1);
      first = 1'b0;
      rem[c]--;
      total--;
      ptr = c;
    end
    rnd_trdy = 1'b1;
    chk_bp   = 1'b1;
    run_until_idle("rnd", 30000);
    rnd_trdy = 1'b0;
    chk_bp   = 1'b0;
    compare_out("rnd");
    chk("rnd_bp_violations", bp_viol, 0);
    chk("rnd_abort", abort_cnt, 0);
  endtask

  task automatic test_stall();
    clear_logs();
    add_frame(1, 15, 8'h10, 1'b0, 1'b0, 10, TMO, 1'b0);
    for (int i = 0; i < 10; i++) exp_q.push_back('{8'(8'h10 + 8'(i)), 1'b0, 1'b0, 0, 0});
    exp_q.push_back('{8'h00, 1'b1, 1'b1, 0, 0});
    run_until_idle("stall", 500);
    compare_out("stall");
    chk("stall_abort_cnt", abort_cnt, 1);
    chk("stall_src_consumed", sq[1].size(), 0);
  endtask

  task automatic test_reset();
    int n;
    clear_logs();
    add_frame(0, 40, 8'h20, 1'b0, 1'b0, -1, 0, 1'b0);
    n = 0;
    while (hs_cyc_q.size() < 20 && n < 200) begin cycle(); n++; end
    chk("rst_reached_byte20", hs_cyc_q.size() >= 20, 1);
    s_sreset = 1'b1;
    for (int s = 0; s < NS; s++) begin sq[s].delete(); wait_c[s] = 0; end
    s_axis_tvalid = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    @(posedge clk);
    #1;
    s_sreset = 1'b0;
    @(negedge clk);
    check_reset("rst");
    clear_logs();
    add_frame(0, 8, 8'h50, 1'b0, 1'b0, -1, 0, 1'b1);
    add_frame(1, 8, 8'h60, 1'b1, 1'b0, -1, 0, 1'b1);
    run_until_idle("rst_after", 500);
    compare_out("rst_after");
    if (hs_grant_q.size() > 0) chk("rst_first_grant", hs_grant_q[0], 0);
    else chk("rst_any_grant", hs_grant_q.size(), 16);
  endtask

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    rnd_trdy = 1'b0; chk_bp = 1'b0;
    for (int s = 0; s < NS; s++) wait_c[s] = 0;
    s_sreset = 1'b1;
    s_axis_tdata = '0; s_axis_tvalid = '0; s_axis_tlast = '0; s_axis_tuser = '0;
    m_axis_trdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_sreset = 1'b0;
    @(negedge clk);
    check_reset("init");
    test_table();
    test_pingpong();
    test_random();
    test_stall();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout: running at %0t, expected to finish before 600000", $time);
    $fatal(1, "global timeout");
  end

endmodule
